// File: rtl/pulp_cg_pkg.sv
// Shared types and counter-width helpers for the per-channel clock-gate controller.
package pulp_cg_pkg;

  typedef enum logic [1:0] {
    GATED    = 2'd0,
    WAKING   = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } cg_state_e;

  localparam int unsigned CG_MAX_WAKE_CYCLES = 32'd255;
  localparam int unsigned CG_MAX_IDLE_CYCLES = 32'd65535;
  localparam int unsigned CG_MAX_CHANNELS    = 32'd32;

  // A counter loaded with cycles-1 and stopped at zero needs enough bits for the value itself.
  function automatic int unsigned cg_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 32'd1);
  endfunction

  localparam int unsigned CG_WAKE_W_MAX = cg_cnt_width(CG_MAX_WAKE_CYCLES);
  localparam int unsigned CG_IDLE_W_MAX = cg_cnt_width(CG_MAX_IDLE_CYCLES);

endpackage

// File: rtl/pulp_clock_gate_ch.sv
// One gated-clock channel: wake/cooldown FSM with registered enable and acknowledge.
module pulp_clock_gate_ch
  import pulp_cg_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 32'd2,
  parameter int unsigned IDLE_CYCLES = 32'd16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic test_en_i,
  input  logic req_i,
  input  logic busy_i,
  output logic clk_o,
  output logic active_o,
  output logic en_o
);

  localparam int unsigned WAKE_W = cg_cnt_width(WAKE_CYCLES);
  localparam int unsigned IDLE_W = cg_cnt_width(IDLE_CYCLES);

  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 32'd1);
  localparam logic [WAKE_W-1:0] WAKE_ZERO = WAKE_W'(32'd0);
  localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(32'd1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYCLES - 32'd1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(32'd0);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(32'd1);

  cg_state_e         state_r;
  cg_state_e         state_nxt_s;
  logic [WAKE_W-1:0] wake_cnt_r;
  logic [WAKE_W-1:0] wake_cnt_nxt_s;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_nxt_s;
  logic              en_r;
  logic              en_nxt_s;
  logic              active_r;
  logic              active_nxt_s;
  logic              demand_s;

  assign demand_s = req_i | busy_i;

  // State, counters and the two observable outputs, all updated on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= GATED;
      wake_cnt_r <= WAKE_ZERO;
      idle_cnt_r <= IDLE_ZERO;
      en_r       <= 1'b0;
      active_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wake_cnt_r <= wake_cnt_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      en_r       <= en_nxt_s;
      active_r   <= active_nxt_s;
    end
  end

  // Next-state and counter logic; a counter is cleared whenever its state is left.
  always_comb begin
    state_nxt_s    = state_r;
    wake_cnt_nxt_s = wake_cnt_r;
    idle_cnt_nxt_s = idle_cnt_r;
    case (state_r)
      GATED: begin
        if (demand_s) begin
          state_nxt_s    = WAKING;
          wake_cnt_nxt_s = WAKE_LOAD;
        end else begin
          state_nxt_s    = GATED;
        end
      end
      WAKING: begin
        // The wake always completes, even if demand disappears meanwhile.
        if (wake_cnt_r == WAKE_ZERO) begin
          state_nxt_s    = ACTIVE;
        end else begin
          wake_cnt_nxt_s = wake_cnt_r - WAKE_ONE;
        end
      end
      ACTIVE: begin
        if (!demand_s) begin
          state_nxt_s    = COOLDOWN;
          idle_cnt_nxt_s = IDLE_LOAD;
        end else begin
          state_nxt_s    = ACTIVE;
        end
      end
      COOLDOWN: begin
        if (demand_s) begin
          state_nxt_s    = ACTIVE;
          idle_cnt_nxt_s = IDLE_ZERO;
        end else if (idle_cnt_r == IDLE_ZERO) begin
          state_nxt_s    = GATED;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r - IDLE_ONE;
        end
      end
      default: begin
        state_nxt_s    = GATED;
        wake_cnt_nxt_s = WAKE_ZERO;
        idle_cnt_nxt_s = IDLE_ZERO;
      end
    endcase
  end

  // Output decode of the next state so the registered outputs track state_r exactly.
  always_comb begin
    en_nxt_s     = 1'b0;
    active_nxt_s = 1'b0;
    case (state_nxt_s)
      GATED: begin
        en_nxt_s     = 1'b0;
        active_nxt_s = 1'b0;
      end
      WAKING: begin
        en_nxt_s     = 1'b1;
        active_nxt_s = 1'b0;
      end
      ACTIVE, COOLDOWN: begin
        en_nxt_s     = 1'b1;
        active_nxt_s = 1'b1;
      end
      default: begin
        en_nxt_s     = 1'b0;
        active_nxt_s = 1'b0;
      end
    endcase
  end

  assign en_o     = en_r;
  assign active_o = active_r;

  pulp_clock_gating i_cg (
    .clk_i     (clk_i),
    .en_i      (en_r),
    .test_en_i (test_en_i),
    .clk_o     (clk_o)
  );

endmodule

// File: rtl/pulp_clock_gating.sv
// Technology-mapped glitch-free clock gate: latch transparent while clk_i is low.
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic clk_en;

  // Enable latch, closed during the high phase so clk_o can never be truncated.
  always_latch begin
    if (clk_i == 1'b0) begin
      clk_en <= en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/pulp_clock_gate_ctrl.sv
// Array of independent gated-clock channels sharing one source clock and scan bypass.
module pulp_clock_gate_ctrl
  import pulp_cg_pkg::*;
#(
  parameter int unsigned NB_CH       = 32'd4,
  parameter int unsigned WAKE_CYCLES = 32'd2,
  parameter int unsigned IDLE_CYCLES = 32'd16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_en_i,
  input  logic [NB_CH-1:0] req_i,
  input  logic [NB_CH-1:0] busy_i,
  output logic [NB_CH-1:0] clk_o,
  output logic [NB_CH-1:0] active_o,
  output logic [NB_CH-1:0] en_o
);

  for (genvar ch = 0; ch < NB_CH; ch++) begin : g_ch
    pulp_clock_gate_ch #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .IDLE_CYCLES (IDLE_CYCLES)
    ) i_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .test_en_i (test_en_i),
      .req_i     (req_i[ch]),
      .busy_i    (busy_i[ch]),
      .clk_o     (clk_o[ch]),
      .active_o  (active_o[ch]),
      .en_o      (en_o[ch])
    );
  end

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Scoreboard bench: each step holds stimulus plus the expected en/active/clk for that cycle.
module tb_pulp_clock_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       te;
  logic [3:0] req;
  logic [3:0] busy;
  logic [3:0] gclk;
  logic [3:0] act;
  logic [3:0] en;
  logic [3:0] clk_hi;
  logic [3:0] clk_lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] busy;
    logic       rst;
    logic       te;
    logic [3:0] en;
    logic [3:0] act;
    logic [3:0] gclk;
  } step_t;

  step_t sb[$];

  always #5 clk = ~clk;

  pulp_clock_gate_ctrl #(
    .NB_CH       (4),
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .test_en_i (te),
    .req_i     (req),
    .busy_i    (busy),
    .clk_o     (gclk),
    .active_o  (act),
    .en_o      (en)
  );

  task automatic push(input logic [3:0] r, input logic [3:0] b, input logic rs, input logic t,
                      input logic [3:0] e, input logic [3:0] a, input logic [3:0] g);
    step_t s;
    s.req = r; s.busy = b; s.rst = rs; s.te = t; s.en = e; s.act = a; s.gclk = g;
    sb.push_back(s);
  endtask

  // One clock: gated clocks sampled mid high phase, registers mid low phase.
  task automatic tick();
    @(posedge clk); #2; clk_hi = gclk;
    @(negedge clk); #1; clk_lo = gclk;
  endtask

  task automatic test_reset();
    step_t s;
    for (int k = 0; k < 2; k++) push(4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      req = s.req; busy = s.busy; rst = s.rst; te = s.te;
      tick();
      checks += 4;
      if (en !== s.en) begin errors++; $display("FAIL reset en_o got %h want %h", en, s.en); end
      if (act !== s.act) begin errors++; $display("FAIL reset active_o got %h want %h", act, s.act); end
      if (clk_hi !== s.gclk) begin errors++; $display("FAIL reset clk_o_high got %h want %h", clk_hi, s.gclk); end
      if (clk_lo !== 4'h0) begin errors++; $display("FAIL reset clk_o_low got %h want 0", clk_lo); end
    end
  endtask

  task automatic test_wake();
    step_t s;
    push(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0);
    push(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1);
    push(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);
    push(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      req = s.req; busy = s.busy; rst = s.rst; te = s.te;
      tick();
      checks += 4;
      if (en !== s.en) begin errors++; $display("FAIL wake en_o got %h want %h", en, s.en); end
      if (act !== s.act) begin errors++; $display("FAIL wake active_o got %h want %h", act, s.act); end
      if (clk_hi !== s.gclk) begin errors++; $display("FAIL wake clk_o_high got %h want %h", clk_hi, s.gclk); end
      if (clk_lo !== 4'h0) begin errors++; $display("FAIL wake clk_o_low got %h want 0", clk_lo); end
    end
  endtask

  task automatic test_idle();
    step_t s;
    for (int k = 1; k <= 16; k++) push(4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);
    push(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1);
    push(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      req = s.req; busy = s.busy; rst = s.rst; te = s.te;
      tick();
      checks += 4;
      if (en !== s.en) begin errors++; $display("FAIL idle en_o got %h want %h", en, s.en); end
      if (act !== s.act) begin errors++; $display("FAIL idle active_o got %h want %h", act, s.act); end
      if (clk_hi !== s.gclk) begin errors++; $display("FAIL idle clk_o_high got %h want %h", clk_hi, s.gclk); end
      if (clk_lo !== 4'h0) begin errors++; $display("FAIL idle clk_o_low got %h want 0", clk_lo); end
    end
  endtask

  // Busy pulse while the cooldown counter reads 5 must restart a full cooldown.
  task automatic test_rearm();
    step_t s;
    push(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0);
    push(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 4'h0, 4'h2);
    push(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 4'h2, 4'h2);
    for (int k = 1; k <= 11; k++) push(4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h2, 4'h2);
    push(4'h0, 4'h2, 1'b0, 1'b0, 4'h2, 4'h2, 4'h2);
    for (int k = 13; k <= 28; k++) push(4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h2, 4'h2);
    push(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h2);
    push(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      req = s.req; busy = s.busy; rst = s.rst; te = s.te;
      tick();
      checks += 4;
      if (en !== s.en) begin errors++; $display("FAIL rearm en_o got %h want %h", en, s.en); end
      if (act !== s.act) begin errors++; $display("FAIL rearm active_o got %h want %h", act, s.act); end
      if (clk_hi !== s.gclk) begin errors++; $display("FAIL rearm clk_o_high got %h want %h", clk_hi, s.gclk); end
      if (clk_lo !== 4'h0) begin errors++; $display("FAIL rearm clk_o_low got %h want 0", clk_lo); end
    end
  endtask

  // ch2: one-cycle request still completes the wake; ch3: busy held, must be unaffected.
  task automatic test_back_to_back();
    step_t s;
    push(4'h4, 4'h8, 1'b0, 1'b0, 4'hC, 4'h0, 4'h0);
    push(4'h0, 4'h8, 1'b0, 1'b0, 4'hC, 4'h0, 4'hC);
    for (int k = 3; k <= 19; k++) push(4'h0, 4'h8, 1'b0, 1'b0, 4'hC, 4'hC, 4'hC);
    push(4'h0, 4'h8, 1'b0, 1'b0, 4'h8, 4'h8, 4'hC);
    push(4'h0, 4'h8, 1'b0, 1'b0, 4'h8, 4'h8, 4'h8);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      req = s.req; busy = s.busy; rst = s.rst; te = s.te;
      tick();
      checks += 4;
      if (en !== s.en) begin errors++; $display("FAIL b2b en_o got %h want %h", en, s.en); end
      if (act !== s.act) begin errors++; $display("FAIL b2b active_o got %h want %h", act, s.act); end
      if (clk_hi !== s.gclk) begin errors++; $display("FAIL b2b clk_o_high got %h want %h", clk_hi, s.gclk); end
      if (clk_lo !== 4'h0) begin errors++; $display("FAIL b2b clk_o_low got %h want 0", clk_lo); end
    end
  endtask

  // ch2 waking and ch3 cooling down when a one-cycle reset hits.
  task automatic test_midreset();
    step_t s;
    push(4'h4, 4'h0, 1'b0, 1'b0, 4'hC, 4'h8, 4'h8);
    push(4'h4, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hC);
    push(4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0);
    push(4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h4);
    push(4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 4'h4, 4'h4);
    push(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h4);
    push(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      req = s.req; busy = s.busy; rst = s.rst; te = s.te;
      tick();
      checks += 4;
      if (en !== s.en) begin errors++; $display("FAIL midreset en_o got %h want %h", en, s.en); end
      if (act !== s.act) begin errors++; $display("FAIL midreset active_o got %h want %h", act, s.act); end
      if (clk_hi !== s.gclk) begin errors++; $display("FAIL midreset clk_o_high got %h want %h", clk_hi, s.gclk); end
      if (clk_lo !== 4'h0) begin errors++; $display("FAIL midreset clk_o_low got %h want 0", clk_lo); end
    end
  endtask

  // Scan bypass runs every clock but leaves the FSMs on their normal schedule.
  task automatic test_scan();
    step_t s;
    for (int k = 0; k < 3; k++) push(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'hF);
    push(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0, 4'hF);
    push(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0, 4'hF);
    push(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h1, 4'hF);
    push(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      req = s.req; busy = s.busy; rst = s.rst; te = s.te;
      tick();
      checks += 4;
      if (en !== s.en) begin errors++; $display("FAIL scan en_o got %h want %h", en, s.en); end
      if (act !== s.act) begin errors++; $display("FAIL scan active_o got %h want %h", act, s.act); end
      if (clk_hi !== s.gclk) begin errors++; $display("FAIL scan clk_o_high got %h want %h", clk_hi, s.gclk); end
      if (clk_lo !== 4'h0) begin errors++; $display("FAIL scan clk_o_low got %h want 0", clk_lo); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; te = 1'b0; req = 4'h0; busy = 4'h0;
    tick();
    test_reset();
    test_wake();
    test_idle();
    test_rearm();
    test_back_to_back();
    test_midreset();
    test_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulp_clock_gate_ctrl.md
PULP_CLOCK_GATE_CTRL -- requirements
Module: pulp_clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NB_CH, default 4, number of independently gated clock channels (1..32).
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, cycles from enable-on to active_o (1..255).
REQ-003 SHALL have parameter IDLE_CYCLES, default 16, idle cycles before auto-gating (1..65535).
REQ-004 SHALL have port clk_i  input  1  free-running source clock; one clock domain.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port test_en_i  input  1  scan bypass; forces all gated clocks running.
REQ-007 SHALL have port req_i  input  NB_CH  per-channel level request to keep the clock on.
REQ-008 SHALL have port busy_i  input  NB_CH  per-channel activity indication from the clocked logic.
REQ-009 SHALL have port clk_o  output  NB_CH  per-channel gated clock.
REQ-010 SHALL have port active_o  output  NB_CH  per-channel acknowledge: clock on and stable.
REQ-011 SHALL have port en_o  output  NB_CH  per-channel registered enable driven into the gating cell (observability).

Function
REQ-012 SHALL run one FSM per channel with states GATED, WAKING, ACTIVE and COOLDOWN.
REQ-013 In GATED: en_o=0, active_o=0; req_i|busy_i sampled high -> WAKING, wake counter loaded with WAKE_CYCLES-1.
REQ-014 In WAKING: en_o=1, active_o=0; counter decrements each cycle; at counter==0 -> ACTIVE regardless of req_i/busy_i.
REQ-015 In ACTIVE: en_o=1, active_o=1; req_i=0 and busy_i=0 -> COOLDOWN, idle counter loaded with IDLE_CYCLES-1.
REQ-016 In COOLDOWN: en_o=1, active_o=1; req_i|busy_i high -> ACTIVE (counter discarded); else at counter==0 -> GATED; else decrement.
REQ-017 SHALL register en_o and active_o as FSM outputs; there SHALL be no combinational path from req_i/busy_i to en_o.
REQ-018 With WAKE_CYCLES=1, WAKING SHALL last exactly one cycle; with IDLE_CYCLES=1, COOLDOWN SHALL last exactly one cycle.
REQ-019 Counter widths SHALL be $clog2(param+1); counters SHALL never wrap below 0.
REQ-020 Each channel's clk_o SHALL come from a latch-based glitch-free gate on clk_i with E=en_o[ch] and SE=test_en_i; clk_o is held low while gated.
REQ-021 test_en_i SHALL affect only the gate SE input; FSM state, en_o and active_o SHALL be independent of test_en_i.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-023 Deasserting req_i during WAKING SHALL not abort the wake; the channel reaches ACTIVE, then proceeds to COOLDOWN.

Reset
REQ-024 While rst_i is high at a clk_i edge, all channels SHALL enter GATED with en_o=0, active_o=0 and counters 0.
REQ-025 Reset asserted mid-WAKING or mid-COOLDOWN SHALL take effect at the next edge; clk_o stops after the following low phase unless test_en_i=1.
REQ-026 In the first cycle after reset release, req_i/busy_i SHALL be sampled normally.

Structure
REQ-027 Package pulp_cg_pkg SHALL hold the state enum cg_state_e (GATED, WAKING, ACTIVE, COOLDOWN) and counter-width helper constants.
REQ-028 Sub-module pulp_clock_gate_ch SHALL implement one channel (FSM, both counters, gating-cell instance); the top generates NB_CH copies.
REQ-029 The gating-cell instance SHALL be the existing technology-mapped pulp_clock_gating component, unmodified.

Verification
REQ-030 Reset, NB_CH=4: rst_i=1 two cycles, req_i=4'hF -> en_o=0, active_o=0, clk_o low throughout.
REQ-031 WAKE_CYCLES=2: req_i[0] high at edge t -> en_o[0]=1 from t+1, active_o[0]=1 from t+3, first clk_o[0] rising edge at t+2.
REQ-032 IDLE_CYCLES=16: ch0 ACTIVE, req/busy drop at edge t -> active_o[0] stays 1 through t+16, en_o[0]=0 from t+17.
REQ-033 COOLDOWN re-arm: busy_i[1] pulses one cycle at cooldown count 5 -> channel returns to ACTIVE, full 16-cycle cooldown restarts after pulse.
REQ-034 test_en_i=1 with all channels GATED -> clk_o=clk_i on all channels; en_o=0, active_o=0 unchanged.
REQ-035 Mid-op reset: ch2 in WAKING, ch3 in COOLDOWN, rst_i one cycle -> both GATED next cycle; ch2 re-wakes if req_i[2] still high after release.
